// File: rtl/alu_share_arbiter_if.sv
// Request, ALU and response bus between the shared-ALU arbiter and its environment.
// slave = arbiter side; master = requesters, external ALU and response consumer.
interface alu_share_arbiter_if #(
    parameter int NREQ = 2,
    parameter int DW   = 32
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0]          req_ready;
    logic [NREQ-1:0][2:0]     req_op;
    logic [NREQ-1:0][DW-1:0]  req_a;
    logic [NREQ-1:0][DW-1:0]  req_b;
    logic [DW-1:0]            alu_srca;
    logic [DW-1:0]            alu_srcb;
    logic [2:0]               alu_ctrl;
    logic [DW-1:0]            alu_result;
    logic                     alu_zero;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [DW-1:0]            rsp_data;
    logic                     rsp_zero;
    logic [IDW-1:0]           rsp_id;
    logic                     rsp_err;

    modport slave (
        input  req_valid, req_op, req_a, req_b, alu_result, alu_zero, rsp_ready,
        output req_ready, alu_srca, alu_srcb, alu_ctrl,
               rsp_valid, rsp_data, rsp_zero, rsp_id, rsp_err
    );

    modport master (
        output req_valid, req_op, req_a, req_b, alu_result, alu_zero, rsp_ready,
        input  req_ready, alu_srca, alu_srcb, alu_ctrl,
               rsp_valid, rsp_data, rsp_zero, rsp_id, rsp_err
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU among NREQ requesters; registers the result
// onto a valid/ready response. ALU_ARB_FIXED_PRIO_EN selects fixed priority over round-robin.
module alu_share_arbiter #(
    parameter int NREQ = 2,
    parameter int DW   = 32
) (
    input logic                 clk,
    input logic                 reset,
    alu_share_arbiter_if.slave  bus
);
    localparam int IDW = $clog2(NREQ);

    typedef enum logic {IDLE, FULL} state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   rsp_data_q;
    logic            rsp_zero_q;
    logic [IDW-1:0]  rsp_id_q;
    logic            rsp_err_q;

    logic            can_issue;
    logic            gnt_vld;
    logic            grant;
    logic [IDW-1:0]  gnt_id;
    logic [IDW-1:0]  sel;
    logic            illegal;
    int              idx;

`ifndef ALU_ARB_FIXED_PRIO_EN
    logic [IDW-1:0]  rr_ptr_q;
`endif

    // Reset masks issue so nothing is accepted while reset is held.
    always_comb begin
        can_issue = !reset && (state_q == IDLE || bus.rsp_ready);
        gnt_vld   = 1'b0;
        gnt_id    = '0;
        idx       = 0;
        sel       = '0;
        for (int k = 0; k < NREQ; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            idx = k;
`else
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
`endif
            sel = IDW'(idx);
            if (!gnt_vld && bus.req_valid[sel]) begin
                gnt_vld = 1'b1;
                gnt_id  = sel;
            end
        end
        grant = can_issue && gnt_vld;
    end

    always_comb begin
        bus.req_ready = '0;
        bus.alu_srca  = '0;
        bus.alu_srcb  = '0;
        bus.alu_ctrl  = 3'b000;
        if (grant) begin
            bus.req_ready[gnt_id] = 1'b1;
            bus.alu_srca          = bus.req_a[gnt_id];
            bus.alu_srcb          = bus.req_b[gnt_id];
            bus.alu_ctrl          = bus.req_op[gnt_id];
        end
    end

    assign illegal = bus.alu_ctrl inside {3'b100, 3'b110, 3'b111};

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant) state_d = FULL;
            FULL:    if (bus.rsp_ready && !grant) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rsp_data_q <= '0;
            rsp_zero_q <= 1'b0;
            rsp_id_q   <= '0;
            rsp_err_q  <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            rr_ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (grant) begin
                rsp_data_q <= bus.alu_result;
                rsp_zero_q <= bus.alu_zero;
                rsp_id_q   <= gnt_id;
                rsp_err_q  <= illegal;
`ifndef ALU_ARB_FIXED_PRIO_EN
                rr_ptr_q   <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
`endif
            end
        end
    end

    assign bus.rsp_valid = (state_q == FULL);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_zero  = rsp_zero_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU on the shared bus.
module tb_alu_share_arbiter;
    localparam int NREQ = 2;
    localparam int DW   = 32;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_err;

    alu_share_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

    alu_share_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU: 000 add, 001 sub, 010 and, 011 or, 101 slt, others 0
    always_comb begin
        case (bus.alu_ctrl)
            3'b000:  bus.alu_result = bus.alu_srca + bus.alu_srcb;
            3'b001:  bus.alu_result = bus.alu_srca - bus.alu_srcb;
            3'b010:  bus.alu_result = bus.alu_srca & bus.alu_srcb;
            3'b011:  bus.alu_result = bus.alu_srca | bus.alu_srcb;
            3'b101:  bus.alu_result = {31'd0, $signed(bus.alu_srca) < $signed(bus.alu_srcb)};
            default: bus.alu_result = '0;
        endcase
        bus.alu_zero = (bus.alu_result == '0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rsp(input string tag, input logic [31:0] data, input logic zero,
                           input logic id, input logic err);
        chk({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
        chk({tag, "_data"},  bus.rsp_data, data);
        chk({tag, "_zero"},  32'(bus.rsp_zero), 32'(zero));
        chk({tag, "_id"},    32'(bus.rsp_id), 32'(id));
        chk({tag, "_err"},   32'(bus.rsp_err), 32'(err));
    endtask

    initial begin
        logic exp_id;
        n_chk = 0;
        n_err = 0;
        // T1 reset with both requesters valid
        reset = 1'b1;
        bus.rsp_ready = 1'b1;
        bus.req_valid = 2'b11;
        bus.req_op[0] = 3'b000; bus.req_a[0] = 32'd5; bus.req_b[0] = 32'd7;
        bus.req_op[1] = 3'b001; bus.req_a[1] = 32'd9; bus.req_b[1] = 32'd9;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_ready", 32'(bus.req_ready), 32'd0);
            chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
        end
        reset = 1'b0;
        #1;
        chk("first_grant", 32'(bus.req_ready), 32'b01);
        chk("bus_srca", bus.alu_srca, 32'd5);

        // T2 add 5+7
        @(negedge clk);
        chk_rsp("t2", 32'd12, 1'b0, 1'b0, 1'b0);
        bus.req_valid = 2'b10;
        #1;
        chk("t3_ready", 32'(bus.req_ready), 32'b10);

        // T3 sub 9-9 then slt 3<4
        @(negedge clk);
        chk_rsp("t3_sub", 32'd0, 1'b1, 1'b1, 1'b0);
        bus.req_op[1] = 3'b101; bus.req_a[1] = 32'd3; bus.req_b[1] = 32'd4;
        @(negedge clk);
        chk_rsp("t3_slt", 32'd1, 1'b0, 1'b1, 1'b0);

        // T4 fairness, both valid for 6 cycles
        bus.req_valid = 2'b11;
        bus.req_op[0] = 3'b000; bus.req_a[0] = 32'd1; bus.req_b[0] = 32'd1;
        bus.req_op[1] = 3'b000; bus.req_a[1] = 32'd2; bus.req_b[1] = 32'd2;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp_id = 1'b0;
`else
            exp_id = (i % 2) != 0;
`endif
            chk("t4_valid", 32'(bus.rsp_valid), 32'd1);
            chk("t4_id", 32'(bus.rsp_id), 32'(exp_id));
            chk("t4_data", bus.rsp_data, exp_id ? 32'd4 : 32'd2);
        end

        // T5 backpressure
        bus.req_valid = 2'b01;
        bus.req_op[0] = 3'b010; bus.req_a[0] = 32'hF0; bus.req_b[0] = 32'h3C;
        @(negedge clk);
        chk_rsp("t5_and", 32'h30, 1'b0, 1'b0, 1'b0);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 2'b10;
        bus.req_op[1] = 3'b011; bus.req_a[1] = 32'h0F; bus.req_b[1] = 32'hF0;
        #1;
        chk("t5_stall_ready0", 32'(bus.req_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_rsp("t5_hold", 32'h30, 1'b0, 1'b0, 1'b0);
            chk("t5_stall_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("t5_release_ready", 32'(bus.req_ready), 32'b10);
        @(negedge clk);
        chk_rsp("t5_or", 32'hFF, 1'b0, 1'b1, 1'b0);
        bus.req_valid = 2'b00;
        #1;
        chk("idle_ctrl", 32'(bus.alu_ctrl), 32'd0);
        chk("idle_srca", bus.alu_srca, 32'd0);
        @(negedge clk);
        chk("t5_drain", 32'(bus.rsp_valid), 32'd0);

        // T6 illegal op
        bus.req_valid = 2'b01;
        bus.req_op[0] = 3'b111; bus.req_a[0] = 32'd1; bus.req_b[0] = 32'd1;
        @(negedge clk);
        chk_rsp("t6", 32'd0, 1'b1, 1'b0, 1'b1);

        // Reset discards a held response
        bus.rsp_ready = 1'b0;
        bus.req_valid = 2'b00;
        @(negedge clk);
        chk("held_valid", 32'(bus.rsp_valid), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_drop_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_drop_err", 32'(bus.rsp_err), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
